// File: rtl/psg_volume_scheduler.sv
// Shared 22x8 volume multiplier sequenced across NVOICE PSG voices, with
// per-voice de-zippered volume ramping.
module psg_volume_scheduler #(
    parameter int NVOICE   = 4,
    parameter int RAMP_DIV = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_i,
    input  logic [NVOICE*22-1:0] voice_i,
    input  logic [NVOICE*4-1:0]  vol_i,
    input  logic [NVOICE-1:0]    mute_i,
    output logic [NVOICE*30-1:0] o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 overrun_o
);
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int IW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NVOICE - 1);

    typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

    state_t               state, state_nxt;
    logic [NVOICE*22-1:0] sample_q;
    logic [3:0]           cur     [NVOICE];
    logic [3:0]           cur_nxt [NVOICE];
    logic [CW-1:0]        frame_cnt;
    logic [IW-1:0]        idx;
    logic                 accept, ramp_tick;
    logic [21:0]          sample_sel;
    logic [7:0]           gain_sel;
    logic [29:0]          prod;

    function automatic logic [7:0] gain(input logic [3:0] step);
        case (step)
            4'd0:  gain = 8'd0;
            4'd1:  gain = 8'd1;
            4'd2:  gain = 8'd1;
            4'd3:  gain = 8'd1;
            4'd4:  gain = 8'd2;
            4'd5:  gain = 8'd3;
            4'd6:  gain = 8'd5;
            4'd7:  gain = 8'd8;
            4'd8:  gain = 8'd8;
            4'd9:  gain = 8'd13;
            4'd10: gain = 8'd21;
            4'd11: gain = 8'd34;
            4'd12: gain = 8'd56;
            4'd13: gain = 8'd90;
            4'd14: gain = 8'd151;
            4'd15: gain = 8'd255;
            default: gain = 8'd0;
        endcase
    endfunction

    assign accept    = (state == IDLE) && sample_i;
    assign ramp_tick = accept && (frame_cnt == CNT_LAST);

    // Volume and mute are only consumed by the ramp in the acceptance cycle,
    // so they need no capture register of their own.
    always_comb begin
        for (int unsigned k = 0; k < NVOICE; k++) begin
            cur_nxt[k] = cur[k];
            if (mute_i[k]) begin
                if (cur[k] != 4'd0) cur_nxt[k] = cur[k] - 4'd1;
            end else if (cur[k] < vol_i[k*4 +: 4]) begin
                cur_nxt[k] = cur[k] + 4'd1;
            end else if (cur[k] > vol_i[k*4 +: 4]) begin
                cur_nxt[k] = cur[k] - 4'd1;
            end
        end
    end

    always_comb begin
        sample_sel = sample_q[idx*22 +: 22];
        gain_sel   = gain(cur[idx]);
        prod       = 30'(sample_sel) * 30'(gain_sel);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        valid_o   = 1'b0;
        unique case (state)
            IDLE:  if (sample_i) state_nxt = SCALE;
            SCALE: begin
                busy_o = 1'b1;
                if (idx == IDX_LAST) state_nxt = DONE;
            end
            DONE: begin
                valid_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sample_q  <= '0;
            frame_cnt <= '0;
            idx       <= '0;
            overrun_o <= 1'b0;
            o         <= '0;
            for (int unsigned k = 0; k < NVOICE; k++) cur[k] <= '0;
        end else begin
            overrun_o <= sample_i && (state != IDLE);
            if (accept) begin
                sample_q  <= voice_i;
                idx       <= '0;
                frame_cnt <= ramp_tick ? '0 : frame_cnt + 1'b1;
                if (ramp_tick) begin
                    for (int unsigned k = 0; k < NVOICE; k++) cur[k] <= cur_nxt[k];
                end
            end else if (state == SCALE) begin
                o[idx*30 +: 30] <= prod;
                idx             <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psg_volume_scheduler.sv
// Bench for psg_volume_scheduler: two instances (RAMP_DIV 1 and 4) on shared
// stimulus, a frame-level reference model, and literal spot checks.
`timescale 1ns/1ps
module tb_psg_volume_scheduler;
    localparam int NV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample;
    logic [NV*22-1:0]  voice;
    logic [NV*4-1:0]   vol;
    logic [NV-1:0]     mute;
    logic [NV*30-1:0]  o_f, o_s;
    logic              valid_f, valid_s, busy_f, busy_s, ovr_f, ovr_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    int GAIN [16] = '{0, 1, 1, 1, 2, 3, 5, 8, 8, 13, 21, 34, 56, 90, 151, 255};

    always #5 clk = ~clk;

    psg_volume_scheduler #(.NVOICE(NV), .RAMP_DIV(1)) u_fast (
        .clk_i(clk), .rst_i(rst), .sample_i(sample), .voice_i(voice), .vol_i(vol),
        .mute_i(mute), .o(o_f), .valid_o(valid_f), .busy_o(busy_f), .overrun_o(ovr_f)
    );
    psg_volume_scheduler #(.NVOICE(NV), .RAMP_DIV(4)) u_slow (
        .clk_i(clk), .rst_i(rst), .sample_i(sample), .voice_i(voice), .vol_i(vol),
        .mute_i(mute), .o(o_s), .valid_o(valid_s), .busy_o(busy_s), .overrun_o(ovr_s)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since an accepted frame (0 = idle).
    // Products for the whole frame are computed at acceptance; slice k appears
    // one cycle after its scale slot.
    int     m_age, m_old, m_tgt;
    bit     m_ovr, m_tick;
    int     m_cnt  [2];
    int     m_cur  [2][NV];
    longint m_prod [2][NV];
    longint m_o    [2][NV];

    function automatic int rdiv(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age = 0;
            m_ovr = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0;
                for (int k = 0; k < NV; k++) begin
                    m_cur[i][k] = 0;
                    m_o[i][k]   = 0;
                    m_prod[i][k] = 0;
                end
            end
        end else begin
            m_old = m_age;
            m_ovr = sample && (m_old != 0);
            if (m_old >= 1 && m_old <= NV)
                for (int i = 0; i < 2; i++) m_o[i][m_old-1] = m_prod[i][m_old-1];
            if (m_old == 0 && sample) begin
                for (int i = 0; i < 2; i++) begin
                    m_tick   = (m_cnt[i] == rdiv(i) - 1);
                    m_cnt[i] = m_tick ? 0 : m_cnt[i] + 1;
                    for (int k = 0; k < NV; k++) begin
                        m_tgt = mute[k] ? 0 : int'(vol[k*4 +: 4]);
                        if (m_tick && m_cur[i][k] < m_tgt) m_cur[i][k]++;
                        else if (m_tick && m_cur[i][k] > m_tgt) m_cur[i][k]--;
                        m_prod[i][k] = longint'(voice[k*22 +: 22]) * GAIN[m_cur[i][k]];
                    end
                end
                m_age = 1;
            end else if (m_old == NV + 1) begin
                m_age = 0;
            end else if (m_old != 0) begin
                m_age = m_old + 1;
            end
        end
    end

    function automatic logic [NV*30-1:0] exp_o(input int i);
        logic [NV*30-1:0] r;
        for (int k = 0; k < NV; k++) r[k*30 +: 30] = m_o[i][k][29:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("o_fast",    o_f,     exp_o(0));
            chk("o_slow",    o_s,     exp_o(1));
            chk("busy_fast", busy_f,  (m_age >= 1 && m_age <= NV));
            chk("busy_slow", busy_s,  (m_age >= 1 && m_age <= NV));
            chk("valid_fast", valid_f, (m_age == NV + 1));
            chk("valid_slow", valid_s, (m_age == NV + 1));
            chk("ovr_fast",  ovr_f,   m_ovr);
            chk("ovr_slow",  ovr_s,   m_ovr);
        end
    end

    task automatic pulse(input int gap);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic frame_timed(input int gap);
        int first;
        first  = -1;
        sample = 1'b1;
        for (int j = 1; j <= gap; j++) begin
            @(negedge clk);
            sample = 1'b0;
            if (valid_f && first < 0) first = j;
        end
        chk("valid_cycle", first, 5);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [29:0] sl(input logic [NV*30-1:0] v, input int k);
        return v[k*30 +: 30];
    endfunction

    initial begin
        int n_ovr, n_val, gap;
        rst = 1'b0; sample = 1'b0; voice = '0; vol = '0; mute = '0;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        chk("reset_o", o_f, '0);
        chk("reset_busy", busy_f, 1'b0);
        chk("reset_valid", valid_f, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Full-scale ramp with RAMP_DIV=1.
        vol = {NV{4'd15}};
        voice = {NV{22'h3FFFFF}};
        for (int f = 1; f <= 15; f++) begin
            frame_timed(8);
            if (f == 1)  for (int k = 0; k < NV; k++) chk("ramp_first", sl(o_f, k), 30'h3FFFFF);
            if (f == 15) for (int k = 0; k < NV; k++) chk("ramp_last", sl(o_f, k), 30'h3FBFFF01);
        end

        // Latency and slice order with cur settled at step 7.
        vol = {NV{4'd7}};
        voice = '0;
        repeat (8) pulse(6);
        for (int k = 0; k < NV; k++) voice[k*22 +: 22] = 22'(k + 1);
        sample = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            sample = 1'b0;
            for (int k = 0; k < NV; k++)
                chk("lat_slice", sl(o_f, k), (j >= k + 2) ? 30'(8 * (k + 1)) : 30'd0);
            chk("lat_busy", busy_f, (j <= 4));
            chk("lat_valid", valid_f, (j == 5));
        end
        @(negedge clk);

        // Mute ramp-down on the RAMP_DIV=4 instance.
        do_reset();
        vol = {4'd9, 4'd12, 4'd5, 4'd3};
        voice = {NV{22'd1}};
        repeat (48) pulse(6);
        chk("settle_v0", sl(o_s, 0), 30'd1);
        chk("settle_v1", sl(o_s, 1), 30'd3);
        chk("settle_v2", sl(o_s, 2), 30'd56);
        chk("settle_v3", sl(o_s, 3), 30'd13);
        mute = 4'b0100;
        for (int f = 1; f <= 48; f++) begin
            pulse(6);
            if (f == 4)  chk("mute_f4", sl(o_s, 2), 30'd34);
            if (f == 47) chk("mute_f47", sl(o_s, 2), 30'd1);
        end
        chk("mute_done_v2", sl(o_s, 2), 30'd0);
        chk("mute_done_v0", sl(o_s, 0), 30'd1);
        chk("mute_done_v1", sl(o_s, 1), 30'd3);
        chk("mute_done_v3", sl(o_s, 3), 30'd13);
        mute = '0;

        // Overrun: second strobe 2 cycles in, third right after valid.
        n_ovr = 0; n_val = 0;
        sample = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            sample = (j == 2 || j == 6);
            n_ovr += int'(ovr_f);
            n_val += int'(valid_f);
            if (j == 7) chk("ovr_third_busy", busy_f, 1'b1);
        end
        chk("ovr_count", n_ovr, 1);
        chk("ovr_valid_count", n_val, 2);

        // Async reset in the middle of SCALE.
        vol = {NV{4'd15}};
        voice = {NV{22'd1}};
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_o", o_f, '0);
        chk("midrst_busy", busy_f, 1'b0);
        n_val = 0;
        repeat (4) begin
            @(negedge clk);
            n_val += int'(valid_f);
        end
        chk("midrst_no_valid", n_val, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        pulse(8);
        chk("midrst_gain1", sl(o_f, 0), 30'd1);
        chk("midrst_slow", sl(o_s, 0), 30'd0);

        // Gain table sweep, voice = 1, up then down.
        for (int s = 2; s <= 15; s++) begin
            pulse(6);
            for (int k = 0; k < NV; k++) chk("table_up", sl(o_f, k), 30'(GAIN[s]));
            if (s == 2) chk("table_step2", sl(o_f, 0), 30'd1);
            if (s == 8) chk("table_step8", sl(o_f, 0), 30'd8);
        end
        vol = '0;
        for (int s = 14; s >= 0; s--) begin
            pulse(6);
            for (int k = 0; k < NV; k++) chk("table_down", sl(o_f, k), 30'(GAIN[s]));
        end

        // Randomized frames, including overruns and mid-frame input changes.
        for (int n = 0; n < 400; n++) begin
            gap = int'($urandom_range(1, 9));
            sample = 1'b1;
            @(negedge clk);
            sample = 1'b0;
            for (int k = 0; k < NV; k++) voice[k*22 +: 22] = 22'($urandom);
            vol  = 16'($urandom);
            mute = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            repeat (gap - 1) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
